// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: control and status bundle for the multi-digit BCD countdown timer.
// The master side (the controller) drives load/start/enable/halt.
// The slave side (the timer) returns the count and its status flags.
// DIGITS must match the DIGITS parameter of the attached bcd_down_timer.
interface bcd_down_timer_if #(
   parameter int DIGITS = 4
);

   // Requests from the controller
   logic                  i_load;
   logic [4*DIGITS-1:0]   i_load_val;
   logic                  i_enable;
   logic                  i_halt;

   // Status returned by the timer
   logic [4*DIGITS-1:0]   o_count;
   logic                  o_zero;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_load_err;

   modport master (
      output i_load,
      output i_load_val,
      output i_enable,
      output i_halt,
      input  o_count,
      input  o_zero,
      input  o_busy,
      input  o_done,
      input  o_load_err
   );

   modport slave (
      input  i_load,
      input  i_load_val,
      input  i_enable,
      input  i_halt,
      output o_count,
      output o_zero,
      output o_busy,
      output o_done,
      output o_load_err
   );

endinterface

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: multi-digit packed-BCD countdown timer.
//
// Loading a start value starts the timer. The value then decrements by one on every
// enabled clock, with the borrow rippling across the decimal digits.
// Terminal count (1 -> next) raises a one-cycle done pulse.
// A load whose value contains a non-decimal nibble is rejected with a one-cycle
// load_err pulse, and the load is otherwise ignored.
//
// Per-edge priority: reset > load > halt > decrement.
//
// Optional feature, selected by the macro BCD_TIMER_RELOAD_EN:
//    defined     -> auto-reload: terminal count reloads the last accepted start value
//                   and keeps running, so done repeats every N enabled edges.
//    not defined -> one-shot: terminal count goes to 0 and returns to IDLE.
//                   The reload register is not built.
module bcd_down_timer #(
   parameter int DIGITS = 4
) (
   input  logic               clk,
   input  logic               reset,
   bcd_down_timer_if.slave    bus
);

   localparam int W = 4 * DIGITS;

   localparam logic [W-1:0] C_ZERO = {W{1'b0}};
   localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // BCD helper functions
   // ------------------------------------------------------------------

   // True when every nibble of val is a legal decimal digit (0..9)
   function automatic logic f_bcd_valid(input logic [W-1:0] val);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (val[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction

   // Decrement a packed BCD value by one.
   // Each zero digit under an active borrow wraps to 9 and passes the borrow upward.
   // The first non-zero digit absorbs the borrow.
   // Callers never pass 0, so the borrow never escapes the top digit.
   function automatic logic [W-1:0] f_bcd_dec(input logic [W-1:0] val);
      logic [W-1:0] res;
      logic         borrow;
      res    = val;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (val[4*i +: 4] == 4'd0) begin
               res[4*i +: 4] = 4'd9;
               borrow        = 1'b1;
            end else begin
               res[4*i +: 4] = val[4*i +: 4] - 4'd1;
               borrow        = 1'b0;
            end
         end else begin
            res[4*i +: 4] = val[4*i +: 4];
         end
      end
      return res;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_count;
   logic [W-1:0]    w_count_nxt;
   logic            r_done;
   logic            w_done_nxt;
   logic            r_load_err;
   logic            w_load_err_nxt;
   logic            w_load_ok;
   logic            w_terminal;

`ifdef BCD_TIMER_RELOAD_EN
   logic [W-1:0]    r_reload;
   logic [W-1:0]    w_reload_nxt;
`endif

   assign w_load_ok  = f_bcd_valid(bus.i_load_val);
   assign w_terminal = (r_count == C_ONE);

   // Next-state, next-count and status-pulse decode in reset > load > halt > decrement order
   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_done_nxt     = 1'b0;
      w_load_err_nxt = 1'b0;
`ifdef BCD_TIMER_RELOAD_EN
      w_reload_nxt   = r_reload;
`endif

      if (bus.i_load) begin
         // Load owns the edge whether or not it is accepted
         if (w_load_ok) begin
            w_count_nxt = bus.i_load_val;
`ifdef BCD_TIMER_RELOAD_EN
            w_reload_nxt = bus.i_load_val;
`endif
            if (bus.i_load_val != C_ZERO) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end else begin
            w_load_err_nxt = 1'b1;
         end
      end else if (bus.i_halt) begin
         // Halt only matters in RUN; the count is held either way
         if (r_state == ST_RUN) begin
            w_state_nxt = ST_IDLE;
         end else begin
            w_state_nxt = r_state;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
               if (!bus.i_enable) begin
                  w_state_nxt = ST_RUN;
               end else if (r_count == C_ZERO) begin
                  // Not reachable through legal operation; park safely
                  w_state_nxt = ST_IDLE;
               end else if (w_terminal) begin
                  w_done_nxt = 1'b1;
`ifdef BCD_TIMER_RELOAD_EN
                  w_count_nxt = r_reload;
                  w_state_nxt = ST_RUN;
`else
                  w_count_nxt = C_ZERO;
                  w_state_nxt = ST_IDLE;
`endif
               end else begin
                  w_count_nxt = f_bcd_dec(r_count);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = r_count;
            end
         endcase
      end
   end

   // State, count and pulse registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_count    <= C_ZERO;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_done     <= w_done_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

`ifdef BCD_TIMER_RELOAD_EN
   // Last accepted start value, restored at every terminal count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reload <= C_ZERO;
      end else begin
         r_reload <= w_reload_nxt;
      end
   end
`endif

   assign bus.o_count    = r_count;
   assign bus.o_zero     = (r_count == C_ZERO);
   assign bus.o_busy     = (r_state == ST_RUN);
   assign bus.o_done     = r_done;
   assign bus.o_load_err = r_load_err;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed and short random checks of bcd_down_timer.
// The reference model works on plain integers and converts to BCD only for comparison.
// Every tick compares all outputs against the model.
// Literal checks pin the main scenarios.
// The expectations follow BCD_TIMER_RELOAD_EN when that macro is defined for the build.
module tb_bcd_down_timer;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bcd_down_timer_if #(.DIGITS(DIGITS)) bus ();

   bcd_down_timer #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Integer-level reference model
   int m_val  = 0;
   int m_rel  = 0;
   bit m_run  = 1'b0;
   bit m_done = 1'b0;
   bit m_err  = 1'b0;

   function automatic bit bcd_ok(input logic [W-1:0] v);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (((v >> (4*i)) & 16'hF) > 16'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic int bcd_to_int(input logic [W-1:0] v);
      int r;
      int p;
      r = 0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r = r + int'((v >> (4*i)) & 16'hF) * p;
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] int_to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference model: same-edge rules reset > load > halt > decrement
   always @(posedge clk) begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (reset) begin
         m_val = 0;
         m_rel = 0;
         m_run = 1'b0;
      end else if (bus.i_load) begin
         if (bcd_ok(bus.i_load_val)) begin
            m_val = bcd_to_int(bus.i_load_val);
            m_rel = m_val;
            m_run = (m_val != 0);
         end else begin
            m_err = 1'b1;
         end
      end else if (bus.i_halt) begin
         m_run = 1'b0;
      end else if (m_run && bus.i_enable) begin
         if (m_val == 1) begin
            m_done = 1'b1;
`ifdef BCD_TIMER_RELOAD_EN
            m_val = m_rel;
`else
            m_val = 0;
            m_run = 1'b0;
`endif
         end else begin
            m_val = m_val - 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare every output with the model
   task automatic tick();
      logic [W+3:0] act;
      logic [W+3:0] exp;
      @(negedge clk);
      act = {bus.o_count, bus.o_zero, bus.o_busy, bus.o_done, bus.o_load_err};
      exp = {int_to_bcd(m_val), (m_val == 0), m_run, m_done, m_err};
      chk("cycle {count,zero,busy,done,err}", 32'(act), 32'(exp));
   endtask

   logic [W-1:0] exp_cnt;
   logic         exp_busy;
   int           n;
   int           r;

   initial begin
      reset          = 1'b1;
      bus.i_load     = 1'b0;
      bus.i_load_val = 16'h0000;
      bus.i_enable   = 1'b0;
      bus.i_halt     = 1'b0;

      // Reset for two cycles
      tick();
      tick();
      reset = 1'b0;
      chk("rst_count", 32'(bus.o_count), 32'h0000);
      chk("rst_zero", 32'(bus.o_zero), 32'd1);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_done", 32'(bus.o_done), 32'd0);
      chk("rst_err", 32'(bus.o_load_err), 32'd0);

      // Borrow chain from 0103 with enable held high
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0103;
      bus.i_enable   = 1'b1;
      tick();
      bus.i_load = 1'b0;
      chk("load_count", 32'(bus.o_count), 32'h0103);
      chk("load_busy", 32'(bus.o_busy), 32'd1);
      tick();
      chk("dec_0102", 32'(bus.o_count), 32'h0102);
      tick();
      tick();
      tick();
      chk("borrow_0099", 32'(bus.o_count), 32'h0099);
      n = 4;
      while (bus.o_done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("done_edges", 32'(n), 32'd103);
`ifdef BCD_TIMER_RELOAD_EN
      exp_cnt  = 16'h0103;
      exp_busy = 1'b1;
`else
      exp_cnt  = 16'h0000;
      exp_busy = 1'b0;
`endif
      chk("terminal_count", 32'(bus.o_count), 32'(exp_cnt));
      tick();
      chk("done_one_cycle", 32'(bus.o_done), 32'd0);
      chk("after_busy", 32'(bus.o_busy), 32'(exp_busy));
      bus.i_enable = 1'b0;
      tick();

      // Invalid load leaves count and state alone
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0042;
      tick();
      bus.i_load_val = 16'h00A5;
      tick();
      bus.i_load = 1'b0;
      chk("bad_err", 32'(bus.o_load_err), 32'd1);
      chk("bad_count", 32'(bus.o_count), 32'h0042);
      chk("bad_busy", 32'(bus.o_busy), 32'd1);
      tick();
      chk("bad_err_clear", 32'(bus.o_load_err), 32'd0);

      // Enable gaps, then halt
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0010;
      tick();
      bus.i_load   = 1'b0;
      bus.i_enable = 1'b1;
      tick();
      tick();
      tick();
      bus.i_enable = 1'b0;
      tick();
      tick();
      chk("gap_hold", 32'(bus.o_count), 32'h0007);
      bus.i_enable = 1'b1;
      tick();
      chk("gap_count", 32'(bus.o_count), 32'h0006);
      bus.i_enable = 1'b0;
      bus.i_halt   = 1'b1;
      tick();
      bus.i_halt = 1'b0;
      chk("halt_busy", 32'(bus.o_busy), 32'd0);
      bus.i_enable = 1'b1;
      tick();
      tick();
      chk("halt_hold", 32'(bus.o_count), 32'h0006);

      // Load wins over terminal count
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0002;
      tick();
      bus.i_load = 1'b0;
      tick();
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0020;
      tick();
      bus.i_load = 1'b0;
      chk("ld_tc_count", 32'(bus.o_count), 32'h0020);
      chk("ld_tc_busy", 32'(bus.o_busy), 32'd1);
      chk("ld_tc_done", 32'(bus.o_done), 32'd0);

      // Halt wins over terminal count
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0002;
      tick();
      bus.i_load = 1'b0;
      tick();
      bus.i_halt = 1'b1;
      tick();
      bus.i_halt = 1'b0;
      chk("halt_tc_count", 32'(bus.o_count), 32'h0001);
      chk("halt_tc_done", 32'(bus.o_done), 32'd0);
      chk("halt_tc_busy", 32'(bus.o_busy), 32'd0);

      // Loading zero stays idle without done
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0000;
      tick();
      bus.i_load = 1'b0;
      chk("ld0_busy", 32'(bus.o_busy), 32'd0);
      chk("ld0_done", 32'(bus.o_done), 32'd0);

      // Reset mid-run
      bus.i_enable   = 1'b0;
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0050;
      tick();
      bus.i_load = 1'b0;
      chk("pre_rst_count", 32'(bus.o_count), 32'h0050);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_count", 32'(bus.o_count), 32'h0000);
      chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
      chk("mid_rst_zero", 32'(bus.o_zero), 32'd1);

      // Short run from 3: reload or one-shot
      bus.i_load     = 1'b1;
      bus.i_load_val = 16'h0003;
      bus.i_enable   = 1'b1;
      tick();
      bus.i_load = 1'b0;
      tick();
      tick();
      chk("short_one", 32'(bus.o_count), 32'h0001);
      tick();
      chk("short_done", 32'(bus.o_done), 32'd1);
`ifdef BCD_TIMER_RELOAD_EN
      chk("short_tc", 32'(bus.o_count), 32'h0003);
      tick();
      tick();
      tick();
      chk("reload_done2", 32'(bus.o_done), 32'd1);
      chk("reload_count2", 32'(bus.o_count), 32'h0003);
      chk("reload_busy", 32'(bus.o_busy), 32'd1);
`else
      chk("short_tc", 32'(bus.o_count), 32'h0000);
      tick();
      tick();
      tick();
      chk("oneshot_done2", 32'(bus.o_done), 32'd0);
      chk("oneshot_count2", 32'(bus.o_count), 32'h0000);
      chk("oneshot_busy", 32'(bus.o_busy), 32'd0);
`endif

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         r              = int'($urandom_range(0, 99));
         bus.i_load     = (r < 6);
         bus.i_halt     = (r >= 6 && r < 8);
         reset          = (r == 99);
         bus.i_enable   = ($urandom_range(0, 3) != 0);
         bus.i_load_val = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
         if (r == 0) bus.i_load_val = 16'h00B3;
         tick();
      end
      reset        = 1'b0;
      bus.i_load   = 1'b0;
      bus.i_halt   = 1'b0;
      bus.i_enable = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
